// File: rtl/hazard_unit.sv
// Pipeline hazard unit: tracks in-flight destinations after D, derives stalls and
// forwarding selects, and sequences the multi-cycle mult/div busy window.
//
// MD state | meaning
// ---------+-----------------------------------------------------------
// MD_IDLE  | mult/div unit free; waits for a md_start entry in stage 1
// MD_BUSY  | unit occupied; md_cnt counts remaining busy cycles
//
// STAGES must be at least 3 (E, M, W are all referenced directly).
module hazard_unit #(
   parameter int STAGES     = 3,
   parameter int REG_BITS   = 5,
   parameter int MD_LATENCY = 5
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        d_valid,
   input  logic [REG_BITS-1:0]         d_rs,
   input  logic [REG_BITS-1:0]         d_rt,
   input  logic [$clog2(STAGES+1)-1:0] d_rs_tuse,
   input  logic [$clog2(STAGES+1)-1:0] d_rt_tuse,
   input  logic [REG_BITS-1:0]         d_dest,
   input  logic [$clog2(STAGES+1)-1:0] d_tnew,
   input  logic                        d_md_start,
   input  logic                        d_md_use,
   output logic                        stall,
   output logic [$clog2(STAGES+1)-1:0] fwd_d_rs,
   output logic [$clog2(STAGES+1)-1:0] fwd_d_rt,
   output logic [$clog2(STAGES+1)-1:0] fwd_e_rs,
   output logic [$clog2(STAGES+1)-1:0] fwd_e_rt,
   output logic [$clog2(STAGES+1)-1:0] fwd_m_rt,
   output logic                        md_busy
);

   localparam int SW = $clog2(STAGES+1);
   localparam logic [SW-1:0] NOUSE = {SW{1'b1}};

   typedef struct packed {
      logic                valid;
      logic                md_start;
      logic [REG_BITS-1:0] dest;
      logic [SW-1:0]       tnew;
      logic [REG_BITS-1:0] rs;
      logic [REG_BITS-1:0] rt;
   } entry_t;

   typedef struct packed {
      logic          hit;
      logic [SW-1:0] stage;
      logic [SW-1:0] tnew;
   } prod_t;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

   entry_t [STAGES:1] pipe;
   md_state_t         md_state;
   logic [7:0]        md_cnt;

   prod_t d_rs_p, d_rt_p, e_rs_p, e_rt_p, m_rt_p;
   logic  rs_stall, rt_stall, md_stall, e_md_start;

   // Scan oldest to youngest so the youngest match overwrites older ones.
   function automatic prod_t find_producer(input entry_t [STAGES:1] p,
                                           input logic [REG_BITS-1:0] r,
                                           input int first);
      prod_t res;
      res = '0;
      for (int k = STAGES; k >= 1; k--) begin
         if (k >= first && p[k].valid && p[k].dest == r && r != '0) begin
            res.hit   = 1'b1;
            res.stage = SW'(k);
            res.tnew  = p[k].tnew;
         end
      end
      return res;
   endfunction

   function automatic entry_t age(input entry_t e);
      entry_t res;
      res = e;
      if (e.tnew != '0) begin
         res.tnew = e.tnew - SW'(1);
      end
      return res;
   endfunction

   always_comb begin
      d_rs_p = find_producer(pipe, d_rs, 1);
      d_rt_p = find_producer(pipe, d_rt, 1);
      e_rs_p = find_producer(pipe, pipe[1].rs, 2);
      e_rt_p = find_producer(pipe, pipe[1].rt, 2);
      m_rt_p = find_producer(pipe, pipe[2].rt, 3);
   end

   assign fwd_d_rs = (d_rs_p.hit && d_rs_p.tnew == '0) ? d_rs_p.stage : '0;
   assign fwd_d_rt = (d_rt_p.hit && d_rt_p.tnew == '0) ? d_rt_p.stage : '0;
   assign fwd_e_rs = (e_rs_p.hit && e_rs_p.tnew == '0) ? e_rs_p.stage : '0;
   assign fwd_e_rt = (e_rt_p.hit && e_rt_p.tnew == '0) ? e_rt_p.stage : '0;
   assign fwd_m_rt = (m_rt_p.hit && m_rt_p.tnew == '0) ? m_rt_p.stage : '0;

   assign rs_stall   = d_valid && (d_rs_tuse != NOUSE) && d_rs_p.hit && (d_rs_p.tnew > d_rs_tuse);
   assign rt_stall   = d_valid && (d_rt_tuse != NOUSE) && d_rt_p.hit && (d_rt_p.tnew > d_rt_tuse);
   assign e_md_start = pipe[1].valid && pipe[1].md_start;
   assign md_stall   = d_valid && (d_md_start || d_md_use) && (md_busy || e_md_start);
   assign stall      = rs_stall || rt_stall || md_stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         pipe <= '0;
      end else begin
         if (d_valid && !stall) begin
            pipe[1] <= '{valid: 1'b1, md_start: d_md_start, dest: d_dest,
                         tnew: d_tnew, rs: d_rs, rt: d_rt};
         end else begin
            pipe[1] <= '0;
         end
         for (int k = 2; k <= STAGES; k++) begin
            pipe[k] <= age(pipe[k-1]);
         end
      end
   end

   // md_busy is registered alongside the state so it always equals (state == BUSY).
   always_ff @(posedge clk) begin
      if (reset) begin
         md_state <= MD_IDLE;
         md_cnt   <= '0;
         md_busy  <= 1'b0;
      end else begin
         case (md_state)
            MD_IDLE: begin
               if (e_md_start) begin
                  md_state <= MD_BUSY;
                  md_cnt   <= 8'(MD_LATENCY);
                  md_busy  <= 1'b1;
               end
            end
            MD_BUSY: begin
               if (md_cnt == 8'd1) begin
                  md_state <= MD_IDLE;
                  md_cnt   <= '0;
                  md_busy  <= 1'b0;
               end else begin
                  md_cnt <= md_cnt - 8'd1;
               end
            end
            default: begin
               md_state <= MD_IDLE;
               md_cnt   <= '0;
               md_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a per-cycle vector trace for stall/forwarding
// behaviour, plus hand-written mult/div busy and mid-busy reset sequences.
module tb_hazard_unit;

   localparam logic [1:0] NU = 2'd3;

   logic       clk = 1'b0;
   logic       reset;
   logic       d_valid;
   logic [4:0] d_rs, d_rt, d_dest;
   logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew;
   logic       d_md_start, d_md_use;
   logic       stall, md_busy;
   logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_unit #(.STAGES(3), .REG_BITS(5), .MD_LATENCY(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .d_valid    (d_valid),
      .d_rs       (d_rs),
      .d_rt       (d_rt),
      .d_rs_tuse  (d_rs_tuse),
      .d_rt_tuse  (d_rt_tuse),
      .d_dest     (d_dest),
      .d_tnew     (d_tnew),
      .d_md_start (d_md_start),
      .d_md_use   (d_md_use),
      .stall      (stall),
      .fwd_d_rs   (fwd_d_rs),
      .fwd_d_rt   (fwd_d_rt),
      .fwd_e_rs   (fwd_e_rs),
      .fwd_e_rt   (fwd_e_rt),
      .fwd_m_rt   (fwd_m_rt),
      .md_busy    (md_busy)
   );

   typedef struct {
      string       name;
      logic        rst;
      logic        v;
      logic [4:0]  rs;
      logic [1:0]  rs_u;
      logic [4:0]  rt;
      logic [1:0]  rt_u;
      logic [4:0]  dest;
      logic [1:0]  tnew;
      logic        mds;
      logic        mdu;
      logic [11:0] exp;
   } vec_t;

   vec_t vecs[$];

   // {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, md_busy}
   function automatic logic [11:0] ex(input logic s, input logic [1:0] fdrs, input logic [1:0] fdrt,
                                      input logic [1:0] fers, input logic [1:0] fert,
                                      input logic [1:0] fmrt, input logic b);
      return {s, fdrs, fdrt, fers, fert, fmrt, b};
   endfunction

   function automatic logic [11:0] outs();
      return {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, md_busy};
   endfunction

   task automatic add(input string n, input logic r, input logic v, input logic [4:0] rs,
                      input logic [1:0] rs_u, input logic [4:0] rt, input logic [1:0] rt_u,
                      input logic [4:0] dest, input logic [1:0] tnew, input logic mds,
                      input logic mdu, input logic [11:0] e);
      vec_t x;
      x.name = n; x.rst = r; x.v = v; x.rs = rs; x.rs_u = rs_u; x.rt = rt; x.rt_u = rt_u;
      x.dest = dest; x.tnew = tnew; x.mds = mds; x.mdu = mdu; x.exp = e;
      vecs.push_back(x);
   endtask

   task automatic drive(input logic v, input logic [4:0] rs, input logic [1:0] rs_u,
                        input logic [4:0] rt, input logic [1:0] rt_u, input logic [4:0] dest,
                        input logic [1:0] tnew, input logic mds, input logic mdu);
      d_valid = v; d_rs = rs; d_rs_tuse = rs_u; d_rt = rt; d_rt_tuse = rt_u;
      d_dest = dest; d_tnew = tnew; d_md_start = mds; d_md_use = mdu;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, NU, 5'd0, NU, 5'd0, 2'd0, 1'b0, 1'b0);
   endtask

   task automatic check(input string n, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %b want %b", n, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      idle();
      @(negedge clk);
      reset = 1'b0;
   endtask

   logic [11:0] busy_stall;
   logic [6:0]  exp_stall;
   logic [6:0]  exp_busy;

   initial begin
      reset = 1'b1;
      idle();
      repeat (2) @(negedge clk);
      reset = 1'b0;

      //   name              rst v  rs  rsu rt  rtu dst tn mds mdu expected
      add("rst_state",       0, 0, 0,  NU, 0,  NU, 0,  0, 0, 0, ex(0,0,0,0,0,0,0));
      add("lw8",             0, 1, 29, 1,  0,  NU, 8,  2, 0, 0, ex(0,0,0,0,0,0,0));
      add("lu_stall",        0, 1, 8,  1,  9,  1,  10, 1, 0, 0, ex(1,0,0,0,0,0,0));
      add("lu_issue",        0, 1, 8,  1,  9,  1,  10, 1, 0, 0, ex(0,0,0,0,0,0,0));
      add("lu_fwd_e",        0, 0, 0,  NU, 0,  NU, 0,  0, 0, 0, ex(0,0,0,3,0,0,0));
      add("addu9",           0, 1, 1,  1,  2,  1,  9,  1, 0, 0, ex(0,0,0,0,0,0,0));
      add("br_stall",        0, 1, 9,  0,  10, 0,  0,  0, 0, 0, ex(1,0,3,0,0,0,0));
      add("br_fwd_d",        0, 1, 9,  0,  10, 0,  0,  0, 0, 0, ex(0,2,0,0,0,0,0));
      add("ori0",            0, 1, 9,  1,  0,  NU, 0,  1, 0, 0, ex(0,3,0,3,0,0,0));
      add("r0_reader",       0, 1, 0,  0,  0,  0,  11, 1, 0, 0, ex(0,0,0,0,0,0,0));
      add("jal31",           0, 1, 0,  NU, 0,  NU, 31, 0, 0, 0, ex(0,0,0,0,0,0,0));
      add("addu31",          0, 1, 11, 1,  31, 1,  31, 0, 0, 0, ex(0,2,1,0,0,0,0));
      add("youngest_d",      0, 1, 31, 1,  11, 1,  0,  0, 0, 0, ex(0,1,3,3,2,0,0));
      add("youngest_e_m",    0, 0, 0,  NU, 0,  NU, 0,  0, 0, 0, ex(0,0,0,2,0,3,0));
      add("lw12",            0, 1, 0,  NU, 0,  NU, 12, 2, 0, 0, ex(0,0,0,0,0,0,0));
      add("rt_stall",        0, 1, 12, NU, 12, 0,  0,  0, 0, 0, ex(1,0,0,0,0,0,0));
      add("nouse",           0, 1, 12, NU, 12, NU, 0,  0, 0, 0, ex(0,0,0,0,0,0,0));
      add("bubble_fwd",      0, 0, 12, 0,  0,  NU, 0,  0, 0, 0, ex(0,3,0,3,3,0,0));
      add("lw13",            0, 1, 0,  NU, 0,  NU, 13, 2, 0, 0, ex(0,0,0,0,0,0,0));
      add("invalid_nostall", 0, 0, 13, 0,  0,  NU, 0,  0, 0, 0, ex(0,0,0,0,0,0,0));
      add("lw15",            0, 1, 0,  NU, 0,  NU, 15, 2, 0, 0, ex(0,0,0,0,0,0,0));
      add("rst_in_stall",    1, 1, 15, 0,  13, 0,  0,  0, 0, 0, ex(1,0,3,0,0,0,0));
      add("post_rst",        0, 1, 15, 0,  13, 0,  0,  0, 0, 0, ex(0,0,0,0,0,0,0));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         reset = vecs[i].rst;
         drive(vecs[i].v, vecs[i].rs, vecs[i].rs_u, vecs[i].rt, vecs[i].rt_u,
               vecs[i].dest, vecs[i].tnew, vecs[i].mds, vecs[i].mdu);
         #1;
         check(vecs[i].name, outs(), vecs[i].exp);
      end

      // mult followed by mfhi: E-start cycle plus five busy cycles of stall
      do_reset();
      drive(1'b1, 5'd0, NU, 5'd0, NU, 5'd0, 2'd0, 1'b1, 1'b0);
      #1;
      check("md_mult_issue", {10'd0, stall, md_busy}, 12'd0);
      exp_stall = 7'b0111111;
      exp_busy  = 7'b0111110;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (i == 0) drive(1'b1, 5'd0, NU, 5'd0, NU, 5'd14, 2'd1, 1'b0, 1'b1);
         #1;
         busy_stall = {10'd0, stall, md_busy};
         check($sformatf("md_cycle%0d", i), busy_stall, {10'd0, exp_stall[i], exp_busy[i]});
      end
      @(negedge clk);
      idle();
      #1;
      check("md_after_mfhi", outs(), 12'd0);

      // reset in the third busy cycle releases the queued mfhi immediately
      do_reset();
      drive(1'b1, 5'd0, NU, 5'd0, NU, 5'd0, 2'd0, 1'b1, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (i == 1) drive(1'b1, 5'd0, NU, 5'd0, NU, 5'd14, 2'd1, 1'b0, 1'b1);
         #1;
         check($sformatf("rst_busy_c%0d", i), {10'd0, stall, md_busy},
               {10'd0, 1'b1, (i >= 2)});
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_busy_release", outs(), 12'd0);
      @(negedge clk);
      idle();
      #1;
      check("rst_busy_idle", outs(), 12'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
